// File: rtl/data_mem_bank.sv
// data_mem_bank: MEM-stage data memory with lane-masked stores, extended loads,
// misalignment rejection and a post-reset zero-clear sweep.
module data_mem_bank #(
  parameter int ADDR_W         = 9,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              wen,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W+1:0] Address,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic              dout_valid,
  output logic              misaligned,
  output logic              busy
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {CLEAR, RUN} state_e;

  localparam state_e RST_ST =
    (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic [31:0]       mem_q [DEPTH];
  logic [3:0]        mem_we;
  logic [31:0]       mem_wd;
  logic [ADDR_W-1:0] mem_wa;

  logic [ADDR_W-1:0] idx;
  logic              acc;
  logic              mis;
  logic              ld;

  logic              s1_vld_q, s1_mis_q, s1_sext_q;
  logic [31:0]       s1_word_q;
  logic [1:0]        s1_lane_q, s1_size_q;

  logic              p_vld, p_mis, p_sext;
  logic [31:0]       p_word;
  logic [1:0]        p_lane, p_size;

  logic [7:0]        b_sel;
  logic [15:0]       h_sel;
  logic [31:0]       ext;

  logic [31:0]       dout_q;
  logic              dval_q, mis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_ST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {ADDR_W{1'b1}})
          state_d = RUN;
      end
      RUN: ;
    endcase
  end

  assign busy = (state_q == CLEAR);
  assign idx  = Address[ADDR_W+1:2];
  assign acc  = req & ~busy;
  assign ld   = acc & ~wen & ~mis;

  always_comb begin
    mis = 1'b0;
    unique case (size)
      2'd0: mis = 1'b0;
      2'd1: mis = Address[0];
      2'd2: mis = |Address[1:0];
      2'd3: mis = 1'b1;
    endcase
  end

  // The clear sweep owns the write port while busy.
  always_comb begin
    mem_we = 4'h0;
    mem_wd = 32'h0;
    mem_wa = idx;
    if (busy) begin
      mem_we = 4'hF;
      mem_wa = cnt_q;
    end else if (acc & wen & ~mis) begin
      unique case (size)
        2'd0: begin
          mem_we = 4'b0001 << Address[1:0];
          mem_wd = {4{din[7:0]}};
        end
        2'd1: begin
          mem_we = Address[1] ? 4'b1100 : 4'b0011;
          mem_wd = {2{din[15:0]}};
        end
        default: begin
          mem_we = 4'hF;
          mem_wd = din;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_we[b])
        mem_q[mem_wa][8*b +: 8] <= mem_wd[8*b +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_mis_q  <= 1'b0;
      s1_word_q <= '0;
      s1_lane_q <= '0;
      s1_size_q <= '0;
      s1_sext_q <= 1'b0;
    end else begin
      s1_vld_q <= ld;
      s1_mis_q <= acc & mis;
      if (ld) begin
        s1_word_q <= mem_q[idx];
        s1_lane_q <= Address[1:0];
        s1_size_q <= size;
        s1_sext_q <= sign_ext;
      end
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic        s2_vld_q, s2_mis_q, s2_sext_q;
    logic [31:0] s2_word_q;
    logic [1:0]  s2_lane_q, s2_size_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_vld_q  <= 1'b0;
        s2_mis_q  <= 1'b0;
        s2_word_q <= '0;
        s2_lane_q <= '0;
        s2_size_q <= '0;
        s2_sext_q <= 1'b0;
      end else begin
        s2_vld_q  <= s1_vld_q;
        s2_mis_q  <= s1_mis_q;
        s2_word_q <= s1_word_q;
        s2_lane_q <= s1_lane_q;
        s2_size_q <= s1_size_q;
        s2_sext_q <= s1_sext_q;
      end
    end

    assign p_vld  = s2_vld_q;
    assign p_mis  = s2_mis_q;
    assign p_word = s2_word_q;
    assign p_lane = s2_lane_q;
    assign p_size = s2_size_q;
    assign p_sext = s2_sext_q;
  end else begin : g_lat1
    assign p_vld  = s1_vld_q;
    assign p_mis  = s1_mis_q;
    assign p_word = s1_word_q;
    assign p_lane = s1_lane_q;
    assign p_size = s1_size_q;
    assign p_sext = s1_sext_q;
  end

  always_comb begin
    b_sel = p_word[8*p_lane +: 8];
    h_sel = p_lane[1] ? p_word[31:16] : p_word[15:0];
    unique case (p_size)
      2'd0:    ext = {{24{p_sext & b_sel[7]}}, b_sel};
      2'd1:    ext = {{16{p_sext & h_sel[15]}}, h_sel};
      default: ext = p_word;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      dval_q <= 1'b0;
      mis_q  <= 1'b0;
    end else begin
      dval_q <= p_vld;
      mis_q  <= p_mis;
      if (p_vld)
        dout_q <= ext;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dval_q;
  assign misaligned = mis_q;

endmodule

// File: tb/tb_data_mem_bank.sv
// tb_data_mem_bank: scoreboard bench driving READ_LAT=2 and READ_LAT=1
// instances of data_mem_bank from the same stimulus.
module tb_data_mem_bank;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          wen = 1'b0;
  logic          sext = 1'b0;
  logic [1:0]    size = 2'd0;
  logic [AW+1:0] addr = '0;
  logic [31:0]   din = '0;

  logic [31:0] dout2, dout1;
  logic        v2, v1, m2, m1, b2, b1;

  always #5 clk = ~clk;

  data_mem_bank #(
    .ADDR_W(AW), .READ_LAT(2), .CLEAR_ON_RESET(1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .wen(wen),
    .size(size), .sign_ext(sext), .Address(addr),
    .din(din), .dout(dout2), .dout_valid(v2),
    .misaligned(m2), .busy(b2)
  );

  data_mem_bank #(
    .ADDR_W(AW), .READ_LAT(1), .CLEAR_ON_RESET(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .wen(wen),
    .size(size), .sign_ext(sext), .Address(addr),
    .din(din), .dout(dout1), .dout_valid(v1),
    .misaligned(m1), .busy(b1)
  );

  typedef struct {
    int          due;
    logic        vld;
    logic        mis;
    logic [31:0] d;
  } exp_t;

  exp_t        q1[$];
  exp_t        q2[$];
  exp_t        me;
  logic [31:0] mdl [DEPTH];
  logic [31:0] last1 = '0;
  logic [31:0] last2 = '0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  // Scoreboard: every cycle each instance must match its queue head or idle.
  always @(posedge clk) begin
    cyc++;
    #2;
    me.due = 0; me.vld = 1'b0; me.mis = 1'b0; me.d = last2;
    if (q2.size() > 0 && q2[0].due == cyc) me = q2.pop_front();
    if (!me.vld) me.d = last2;
    n_chk++;
    if ({v2, m2, dout2} !== {me.vld, me.mis, me.d}) begin
      n_fail++;
      $display("FAIL out_lat2 cyc=%0d got v=%b m=%b d=%h exp v=%b m=%b d=%h",
               cyc, v2, m2, dout2, me.vld, me.mis, me.d);
    end
    if (me.vld) last2 = me.d;
    me.due = 0; me.vld = 1'b0; me.mis = 1'b0; me.d = last1;
    if (q1.size() > 0 && q1[0].due == cyc) me = q1.pop_front();
    if (!me.vld) me.d = last1;
    n_chk++;
    if ({v1, m1, dout1} !== {me.vld, me.mis, me.d}) begin
      n_fail++;
      $display("FAIL out_lat1 cyc=%0d got v=%b m=%b d=%h exp v=%b m=%b d=%h",
               cyc, v1, m1, dout1, me.vld, me.mis, me.d);
    end
    if (me.vld) last1 = me.d;
  end

  task automatic issue(input logic w, input logic [1:0] sz,
                       input logic se, input logic [AW+1:0] a,
                       input logic [31:0] d);
    exp_t        e;
    logic        bad;
    logic [31:0] word;
    logic [7:0]  by;
    logic [15:0] hw;
    int          ix, ln, hf;
    req = 1'b1; wen = w; size = sz; sext = se; addr = a; din = d;
    ix = int'(a[AW+1:2]);
    ln = int'(a[1:0]);
    hf = int'(a[1]);
    bad = (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
          (sz == 2'd2 && a[1:0] != 2'd0);
    e.due = 0; e.vld = 1'b0; e.mis = bad; e.d = '0;
    word = mdl[ix];
    if (!bad && w) begin
      case (sz)
        2'd0:    word[8*ln +: 8] = d[7:0];
        2'd1:    word[16*hf +: 16] = d[15:0];
        default: word = d;
      endcase
      mdl[ix] = word;
    end else if (!bad) begin
      e.vld = 1'b1;
      by = word[8*ln +: 8];
      hw = word[16*hf +: 16];
      case (sz)
        2'd0:    e.d = se ? {{24{by[7]}}, by} : {24'h0, by};
        2'd1:    e.d = se ? {{16{hw[15]}}, hw} : {16'h0, hw};
        default: e.d = word;
      endcase
    end
    if (bad || !w) begin
      e.due = cyc + 3; q2.push_back(e);
      e.due = cyc + 2; q1.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req = 1'b0; wen = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    req = 1'b0;
    rst_n = 1'b0;
    q1.delete(); q2.delete();
    last1 = '0; last2 = '0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    #1;
    n_chk++;
    if ({dout2, v2, m2, b2} !== {32'h0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_vals_lat2 got d=%h v=%b m=%b b=%b exp 0/0/0/1",
               dout2, v2, m2, b2);
    end
    n_chk++;
    if ({dout1, v1, m1, b1} !== {32'h0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_vals_lat1 got d=%h v=%b m=%b b=%b exp 0/0/0/1",
               dout1, v1, m1, b1);
    end
    @(negedge clk);
  endtask

  task automatic release_and_count(input logic poke);
    int n = 0;
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (poke) begin
        req = 1'b1; wen = k[0]; size = 2'd2;
        addr = '0; din = 32'hFFFF_FFFF;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!b2) break;
    end
    req = 1'b0; wen = 1'b0;
    n_chk++;
    if (n !== 16 || b1 !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_len got %0d edges (b1=%b) exp 16 edges", n, b1);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    #1;
    n_chk++;
    if ({dout2, v2, m2, b2, b1} !== {32'h0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL init_vals got d=%h v=%b m=%b b=%b/%b", dout2, v2, m2, b2, b1);
    end
    @(negedge clk);
    release_and_count(1'b0);
    for (int i = 0; i < DEPTH; i++)
      issue(1'b1, 2'd2, 1'b0, 6'(i*4), $urandom | 32'h1);
    idle(1);
  endtask

  task automatic test_clear();
    do_reset();
    release_and_count(1'b1);
    for (int i = 0; i < DEPTH; i++)
      issue(1'b0, 2'd2, 1'b0, 6'(i*4), 32'h0);
    idle(3);
  endtask

  task automatic test_lanes();
    issue(1'b1, 2'd2, 1'b0, 6'h10, 32'hDEADBEEF);
    issue(1'b1, 2'd0, 1'b0, 6'h12, 32'h00000055);
    issue(1'b0, 2'd2, 1'b0, 6'h10, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 6'h10, 32'h00001234);
    issue(1'b0, 2'd0, 1'b1, 6'h12, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 6'h10, 32'h0);
    idle(3);
    n_chk++;
    if (dout2 !== 32'hDE551234 || dout1 !== 32'hDE551234) begin
      n_fail++;
      $display("FAIL lanes_word got %h/%h exp DE551234", dout2, dout1);
    end
  endtask

  task automatic test_ext();
    issue(1'b1, 2'd2, 1'b0, 6'h20, 32'h80FF7F01);
    issue(1'b0, 2'd0, 1'b1, 6'h21, 32'h0);
    issue(1'b0, 2'd0, 1'b0, 6'h23, 32'h0);
    issue(1'b0, 2'd1, 1'b1, 6'h22, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 6'h22, 32'h0);
    issue(1'b0, 2'd1, 1'b1, 6'h20, 32'h0);
    issue(1'b0, 2'd0, 1'b1, 6'h20, 32'h0);
    issue(1'b0, 2'd2, 1'b1, 6'h20, 32'h0);
    issue(1'b0, 2'd0, 1'b1, 6'h23, 32'h0);
    idle(3);
    n_chk++;
    if (dout2 !== 32'hFFFFFF80 || dout1 !== 32'hFFFFFF80) begin
      n_fail++;
      $display("FAIL lb_signed got %h/%h exp FFFFFF80", dout2, dout1);
    end
  endtask

  task automatic test_misaligned();
    issue(1'b0, 2'd2, 1'b0, 6'h22, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 6'h11, 32'h0000AAAA);
    issue(1'b0, 2'd3, 1'b0, 6'h20, 32'h0);
    issue(1'b1, 2'd3, 1'b0, 6'h20, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 6'h21, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 6'h10, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 6'h20, 32'h0);
    idle(3);
    n_chk++;
    if (dout2 !== 32'h80FF7F01 || dout1 !== 32'h80FF7F01) begin
      n_fail++;
      $display("FAIL mis_nowrite got %h/%h exp 80FF7F01", dout2, dout1);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    issue(1'b1, 2'd2, 1'b0, 6'h30, 32'h5A5A5A5A);
    idle(3);
    t0 = cyc;
    issue(1'b0, 2'd2, 1'b0, 6'h30, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 6'h30, 32'h00000001);
    issue(1'b0, 2'd2, 1'b0, 6'h30, 32'h0);
    req = 1'b0; wen = 1'b0;
    n_chk++;
    if (cyc != t0 + 3 || !v2 || dout2 !== 32'h5A5A5A5A || v1) begin
      n_fail++;
      $display("FAIL b2b_first got v2=%b d2=%h v1=%b exp 1/5A5A5A5A/0", v2, dout2, v1);
    end
    @(negedge clk);
    n_chk++;
    if (v2 || dout2 !== 32'h5A5A5A5A || !v1 || dout1 !== 32'h1) begin
      n_fail++;
      $display("FAIL b2b_gap got v2=%b d2=%h v1=%b d1=%h exp 0/5A5A5A5A/1/1",
               v2, dout2, v1, dout1);
    end
    @(negedge clk);
    n_chk++;
    if (!v2 || dout2 !== 32'h1) begin
      n_fail++;
      $display("FAIL b2b_second got v2=%b d2=%h exp 1/00000001", v2, dout2);
    end
    idle(2);
  endtask

  task automatic test_random();
    logic [1:0] sz;
    for (int i = 0; i < 60; i++) begin
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
            6'($urandom_range(0, 63)), $urandom);
    end
    idle(3);
  endtask

  task automatic test_mid_reset();
    issue(1'b1, 2'd2, 1'b0, 6'h3C, 32'hCAFEF00D);
    issue(1'b0, 2'd2, 1'b0, 6'h3C, 32'h0);
    idle(4);
    do_reset();
    rst_n = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    do_reset();
    release_and_count(1'b0);
    issue(1'b0, 2'd2, 1'b0, 6'h10, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 6'h20, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 6'h3C, 32'h0);
    issue(1'b0, 2'd0, 1'b1, 6'h23, 32'h0);
    idle(4);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_clear();
    test_lanes();
    test_ext();
    test_misaligned();
    test_back_to_back();
    test_random();
    test_mid_reset();
    idle(6);
    n_chk++;
    if (q1.size() != 0 || q2.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d/%0d pending exp 0/0", q1.size(), q2.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
